// File: rtl/mul_pkg.sv
// Shared definitions for the iterative Booth multiplier: FSM states, Booth digits, step count.
// BOOTH_RADIX4_EN selects radix-4 modified Booth recoding; undefined gives radix-2.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_P1   = 3'd1,
        DIG_P2   = 3'd2,
        DIG_M1   = 3'd3,
        DIG_M2   = 3'd4
    } booth_dig_e;

`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4_EN = 1'b1;
`else
    localparam bit RADIX4_EN = 1'b0;
`endif

    // Bits retired per step and width of the recode window {.., q0, q-1}.
    localparam int SHIFT = RADIX4_EN ? 2 : 1;
    localparam int REC_W = SHIFT + 1;

    // Operands are extended to width+1 bits before recoding.
    function automatic int booth_steps(input int width);
        return RADIX4_EN ? (width + 2) / 2 : width + 1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: recode, add digit*multiplicand, arithmetic shift.
// BOOTH_RADIX4_EN selects the radix-4 digit set; otherwise radix-2.
module booth_step
    import mul_pkg::*;
#(
    parameter int AW = 19,
    parameter int QW = 17
) (
    input  logic [AW+QW:0]  pp_i,
    input  logic [AW-1:0]   mcand_i,
    input  logic [REC_W-1:0] rec_i,
    output logic [AW+QW:0]  pp_o
);

    booth_dig_e     dig;
    logic [AW-1:0]  addend;
    logic [AW-1:0]  acc_sum;
    logic [AW+QW:0] pp_sum;

    always_comb begin
        dig = DIG_ZERO;
`ifdef BOOTH_RADIX4_EN
        case (rec_i)
            3'b001, 3'b010: dig = DIG_P1;
            3'b011:         dig = DIG_P2;
            3'b100:         dig = DIG_M2;
            3'b101, 3'b110: dig = DIG_M1;
            default:        dig = DIG_ZERO;
        endcase
`else
        case (rec_i)
            2'b01:   dig = DIG_P1;
            2'b10:   dig = DIG_M1;
            default: dig = DIG_ZERO;
        endcase
`endif
    end

    always_comb begin
        addend = '0;
        case (dig)
            DIG_P1:  addend = mcand_i;
            DIG_P2:  addend = mcand_i << 1;
            DIG_M1:  addend = -mcand_i;
            DIG_M2:  addend = -(mcand_i << 1);
            default: addend = '0;
        endcase
        acc_sum = pp_i[AW+QW -: AW] + addend;
        pp_sum  = {acc_sum, pp_i[QW:0]};
        pp_o    = $signed(pp_sum) >>> SHIFT;
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative Booth multiplier with start/done handshake; signed or unsigned WIDTH x WIDTH.
// Radix-4 recoding when BOOTH_RADIX4_EN is defined (fewer steps), radix-2 otherwise.
module seq_booth_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResultLo,
    output logic [WIDTH-1:0] oResultHi,
    output logic             oOverflow
);

    localparam int STEPS = booth_steps(WIDTH);
    // Two guard bits above the extended operand keep +/-2M partial sums in range.
    localparam int AW    = WIDTH + 3;
    localparam int QW    = SHIFT * STEPS;
    localparam int PW    = AW + QW + 1;
    localparam int CW    = $clog2(STEPS + 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    pp_q, pp_d, pp_step;
    logic [AW-1:0]    mcand_q, mcand_d;
    logic             signed_q, signed_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             ovf_q, ovf_d;

    logic [AW-1:0]      a_ext;
    logic [QW-1:0]      b_ext;
    logic [2*WIDTH-1:0] prod;
    logic               unused_pp_hi;

    assign a_ext = iSigned ? {{(AW-WIDTH){iA[WIDTH-1]}}, iA} : {{(AW-WIDTH){1'b0}}, iA};
    assign b_ext = iSigned ? {{(QW-WIDTH){iB[WIDTH-1]}}, iB} : {{(QW-WIDTH){1'b0}}, iB};

    // Register layout: {acc[AW], q[QW], q-1}; product sits just above q-1.
    assign prod         = pp_q[2*WIDTH:1];
    assign unused_pp_hi = ^pp_q[PW-1:2*WIDTH+1];

    booth_step #(
        .AW (AW),
        .QW (QW)
    ) u_step (
        .pp_i    (pp_q),
        .mcand_i (mcand_q),
        .rec_i   (pp_q[REC_W-1:0]),
        .pp_o    (pp_step)
    );

    always_comb begin
        state_d  = state_q;
        pp_d     = pp_q;
        mcand_d  = mcand_q;
        signed_d = signed_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        lo_d     = lo_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d  = ST_RUN;
                    mcand_d  = a_ext;
                    signed_d = iSigned;
                    pp_d     = {{AW{1'b0}}, b_ext, 1'b0};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == CW'(STEPS)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    lo_d    = prod[WIDTH-1:0];
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    ovf_d   = signed_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                       : (|prod[2*WIDTH-1:WIDTH]);
                end else begin
                    pp_d   = pp_step;
                    cnt_d  = cnt_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            pp_q     <= '0;
            mcand_q  <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pp_q     <= pp_d;
            mcand_q  <= mcand_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
        end
    end

    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oResultLo = lo_q;
    assign oResultHi = hi_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Randomised bench for seq_booth_multiplier (WIDTH=16 and WIDTH=4) against an integer-arithmetic model.
module tb_seq_booth_multiplier;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st16 = 0, sg16 = 0, bz16, dn16, ov16;
    logic [15:0] a16 = 0, b16 = 0, lo16, hi16;
    logic        st4 = 0, sg4 = 0, bz4, dn4, ov4;
    logic [3:0]  a4 = 0, b4 = 0, lo4, hi4;

    seq_booth_multiplier #(.WIDTH(16)) dut16 (
        .Clock(clk), .Reset(rst_n), .iStart(st16), .iSigned(sg16), .iA(a16), .iB(b16),
        .oBusy(bz16), .oDone(dn16), .oResultLo(lo16), .oResultHi(hi16), .oOverflow(ov16)
    );

    seq_booth_multiplier #(.WIDTH(4)) dut4 (
        .Clock(clk), .Reset(rst_n), .iStart(st4), .iSigned(sg4), .iA(a4), .iB(b4),
        .oBusy(bz4), .oDone(dn4), .oResultLo(lo4), .oResultHi(hi4), .oOverflow(ov4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_lo16 = 0, last_lo4 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic        rd_done(input int w); return (w == 4) ? dn4 : dn16; endfunction
    function automatic logic        rd_busy(input int w); return (w == 4) ? bz4 : bz16; endfunction
    function automatic logic        rd_ovf (input int w); return (w == 4) ? ov4 : ov16; endfunction
    function automatic logic [31:0] rd_lo  (input int w); return (w == 4) ? {28'b0, lo4} : {16'b0, lo16}; endfunction
    function automatic logic [31:0] rd_hi  (input int w); return (w == 4) ? {28'b0, hi4} : {16'b0, hi16}; endfunction

    // Product by plain integer multiplication of the interpreted operand values.
    task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                             output logic [31:0] hi, output logic [31:0] lo, output logic ov);
        longint sa, sb, p, lim, msk;
        msk = (longint'(1) << w) - 1;
        sa  = longint'(a) & msk;
        sb  = longint'(b) & msk;
        if (s && a[w-1]) sa -= (longint'(1) << w);
        if (s && b[w-1]) sb -= (longint'(1) << w);
        p   = sa * sb;
        lim = longint'(1) << (w - 1);
        ov  = s ? ((p < -lim) || (p >= lim)) : (p >= (lim << 1));
        lo  = 32'(p & msk);
        hi  = 32'((p >>> w) & msk);
    endtask

    // Called at a negedge; returns at the negedge just after the DONE cycle.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input bit poke, output logic [31:0] hi, output logic [31:0] lo, output logic ov);
        logic [31:0] e_hi, e_lo, hold;
        logic        e_ov;
        int          lat, steps;
        steps = booth_steps(w);
        ref_model(w, a, b, s, e_hi, e_lo, e_ov);
        hold = (w == 4) ? last_lo4 : last_lo16;
        if (w == 4) begin a4 = a[3:0]; b4 = b[3:0]; sg4 = s; st4 = 1; end
        else        begin a16 = a[15:0]; b16 = b[15:0]; sg16 = s; st16 = 1; end
        @(posedge clk);
        @(negedge clk);
        st4 = 0; st16 = 0;
        a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); sg16 = 1'($urandom);
        chk("busy_after_start", rd_busy(w), 1);
        lat = 0;
        while (!rd_done(w) && lat <= steps + 4) begin
            if (poke && lat == 3) begin
                a16 = 16'd2; b16 = 16'd2; sg16 = 0; st16 = 1;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            st4 = 0; st16 = 0;
            if (!rd_done(w)) chk("lo_hold_run", rd_lo(w), hold);
        end
        chk("latency", lat, steps + 1);
        chk("busy_at_done", rd_busy(w), 0);
        chk("res_hi", rd_hi(w), e_hi);
        chk("res_lo", rd_lo(w), e_lo);
        chk("overflow", rd_ovf(w), e_ov);
        hi = rd_hi(w); lo = rd_lo(w); ov = rd_ovf(w);
        if (w == 4) last_lo4 = e_lo; else last_lo16 = e_lo;
        @(negedge clk);
        chk("done_one_cycle", rd_done(w), 0);
        chk("lo_hold_after", rd_lo(w), e_lo);
    endtask

    logic [31:0] r_hi, r_lo;
    logic        r_ov;

    initial begin
        #1;
        chk("rst_busy", bz16, 0);
        chk("rst_done", dn16, 0);
        chk("rst_lo", lo16, 0);
        chk("rst_hi", hi16, 0);
        chk("rst_ovf", ov16, 0);
        chk("rst_busy4", bz4, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        op(16, 32'hFFFD, 32'h0005, 1, 0, r_hi, r_lo, r_ov);
        chk("m3x5_hi", r_hi, 32'hFFFF); chk("m3x5_lo", r_lo, 32'hFFF1); chk("m3x5_ov", r_ov, 0);
        op(16, 32'h8000, 32'h8000, 1, 0, r_hi, r_lo, r_ov);
        chk("min_sq_hi", r_hi, 32'h4000); chk("min_sq_lo", r_lo, 32'h0000); chk("min_sq_ov", r_ov, 1);
        op(16, 32'hFFFF, 32'hFFFF, 0, 0, r_hi, r_lo, r_ov);
        chk("umax_hi", r_hi, 32'hFFFE); chk("umax_lo", r_lo, 32'h0001); chk("umax_ov", r_ov, 1);
        op(4, 32'h5, 32'hE, 1, 0, r_hi, r_lo, r_ov);
        chk("w4_hi", r_hi, 32'hF); chk("w4_lo", r_lo, 32'h6); chk("w4_ov", r_ov, 1);

        // Restart attempt while busy must be ignored.
        op(16, 32'd7, 32'd3, 0, 1, r_hi, r_lo, r_ov);
        chk("poke_hi", r_hi, 32'h0); chk("poke_lo", r_lo, 32'h15);
        for (int i = 0; i < booth_steps(16) + 3; i++) begin
            chk("no_extra_done", dn16, 0);
            @(negedge clk);
        end
        op(16, 32'd2, 32'd2, 0, 0, r_hi, r_lo, r_ov);
        chk("after_poke_lo", r_lo, 32'h4);

        // Reset partway through an operation.
        a16 = 16'($urandom); b16 = 16'($urandom); sg16 = 1; st16 = 1;
        @(posedge clk);
        @(negedge clk);
        st16 = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort_busy", bz16, 0);
        chk("abort_done", dn16, 0);
        chk("abort_lo", lo16, 0);
        chk("abort_hi", hi16, 0);
        chk("abort_ovf", ov16, 0);
        chk("abort_lo4", lo4, 0);
        last_lo16 = 0; last_lo4 = 0;
        for (int i = 0; i < booth_steps(16) + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", dn16, 0);
        end
        rst_n = 1;
        op(16, 32'h1234, 32'hFEDC, 1, 0, r_hi, r_lo, r_ov);

        for (int i = 0; i < 25; i++)
            op(16, $urandom, $urandom, 1'($urandom), 0, r_hi, r_lo, r_ov);
        for (int i = 0; i < 20; i++)
            op(4, $urandom, $urandom, 1'($urandom), 0, r_hi, r_lo, r_ov);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Iterative Booth multiplier with a start/done handshake. It multiplies two WIDTH-bit operands, signed or unsigned, and returns a 2*WIDTH-bit product split into high and low halves. It is the parametrised successor of the MiniAlu single-cycle SMUL/MUL4bits paths. The ALU control issues iStart and stalls on oBusy, then writes oResultLo and oResultHi to the data RAM on oDone.

Parameters:
WIDTH, 16, operand width in bits; legal range 2..32.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
iStart  input  1  start request; sampled only in IDLE
iSigned  input  1  1 = two's-complement operands, 0 = unsigned; latched with iStart
iA  input  WIDTH  multiplicand; latched with iStart
iB  input  WIDTH  multiplier; latched with iStart
oBusy  output  1  high while an operation is in progress (RUN state)
oDone  output  1  one-cycle pulse; product is valid
oResultLo  output  WIDTH  product bits [WIDTH-1:0]
oResultHi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
oOverflow  output  1  product does not fit in WIDTH bits

Behaviour:
- Reset asserted: the state goes to IDLE immediately (asynchronously). oBusy=0, oDone=0, oResultLo=0, oResultHi=0, oOverflow=0. All internal registers clear.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: if iStart=1 at a rising edge, latch iA, iB and iSigned, clear the accumulator and step counter, and go to RUN. Otherwise stay in IDLE.
- Operand extension: operands are extended to WIDTH+1 bits. Signed mode uses sign extension; unsigned mode uses zero extension. Latency is identical in both modes.
- RUN (radix-2): each cycle performs one Booth step on the multiplier LSB pair {q0, q-1}:
  - 01 adds the multiplicand.
  - 10 subtracts the multiplicand.
  - 00 and 11 add nothing.
  - After the add/subtract, the accumulator/multiplier register does an arithmetic shift right by 1.
  - STEPS = WIDTH+1. After the final step, go to DONE.
- DONE: for one cycle, oDone=1 and oResultHi/oResultLo/oOverflow are updated. The next state is IDLE unconditionally. An iStart during DONE is ignored.
- Latency: if iStart is sampled at edge 0, oDone is high in the cycle following edge STEPS+1. For WIDTH=16 that is edge 18. oBusy is high in the cycles following edges 0..STEPS.
- Result outputs hold their value from the DONE cycle until the next DONE or reset. They do not change during RUN.
- oOverflow:
  - Signed mode: 1 when oResultHi is not the sign extension of oResultLo[WIDTH-1].
  - Unsigned mode: 1 when oResultHi is nonzero.
- iStart while oBusy=1 is ignored. Operands are not re-latched and the current operation completes unchanged.
- Reset asserted mid-RUN aborts the operation. Outputs return to their reset values and no oDone is produced.
- Back-to-back operation: iStart may be asserted in the cycle immediately after DONE (i.e. in IDLE).

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- Defined: the datapath uses radix-4 modified Booth recoding on triplets {q1, q0, q-1}, with digits in {-2, -1, 0, +1, +2} times the multiplicand. Each step shifts by 2. STEPS = ceil((WIDTH+1)/2), giving 9 for WIDTH=16. The handshake and results are otherwise identical.
- Undefined: radix-2 as specified above.

Decomposition:
- Shared package mul_pkg holds:
  - state encoding constants (IDLE, RUN, DONE);
  - the Booth digit encodings;
  - the STEPS expression for both radices, so the bench computes the expected latency from the same source.
- Sub-module booth_step: purely combinational. It takes the partial-product register, the multiplicand and the recode bits, and produces the next register value. It is instantiated once.
- The FSM, counter and operand/result registers live in the top module.

Test Plan:
- WIDTH=16, signed, iA=-3 (0xFFFD), iB=5 -> oResultHi=0xFFFF, oResultLo=0xFFF1, oOverflow=0; oDone pulses exactly one cycle after edge 18 (edge 10 with BOOTH_RADIX4_EN).
- WIDTH=16, signed, iA=iB=0x8000 -> oResultHi=0x4000, oResultLo=0x0000, oOverflow=1.
- WIDTH=16, unsigned, iA=iB=0xFFFF -> oResultHi=0xFFFE, oResultLo=0x0001, oOverflow=1.
- WIDTH=4, signed, iA=5, iB=0xE (-2) -> oResultHi=0xF, oResultLo=0x6, oOverflow=1.
- Start iA=7, iB=3 (unsigned), then pulse iStart with iA=2, iB=2 while oBusy=1 -> one oDone only, result 21 (Hi=0, Lo=0x0015); a subsequent start in IDLE gives 4.
- Assert Reset at edge 5 of a 16-bit operation -> oBusy=0, oDone never pulses, outputs 0. A new start after release gives the correct product with full latency.
